// File: rtl/output_serdes_gearbox.sv
// Parallel-to-narrow gearbox for a bank of OSERDES lanes: one-word hold buffer,
// per-lane shifters emitting OUT_BITS per clock, idle pattern and gap counter when starved.
module output_serdes_gearbox #(
    parameter int unsigned          CHANNELS     = 2,
    parameter int unsigned          DATA_WIDTH   = 8,
    parameter int unsigned          OUT_BITS     = 4,
    parameter bit                   MSB_FIRST    = 1'b0,
    parameter logic [OUT_BITS-1:0]  IDLE_PATTERN = OUT_BITS'(4'b0101)
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           clockEnable,
    input  logic                           inValid,
    output logic                           inReady,
    input  logic [CHANNELS*DATA_WIDTH-1:0] dataIn,
    output logic [CHANNELS*OUT_BITS-1:0]   dataOut,
    output logic                           wordStart,
    output logic [15:0]                    gapCount,
    input  logic                           clearGapCount
);

    localparam int unsigned R  = DATA_WIDTH / OUT_BITS;
    localparam int unsigned SW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned CW = CHANNELS * DATA_WIDTH;
    localparam logic [SW-1:0] LAST = SW'(R - 1);

    if ((OUT_BITS < 1) || (OUT_BITS > 8) || ((DATA_WIDTH % OUT_BITS) != 0)) begin : gBadParams
        $error("output_serdes_gearbox: OUT_BITS must be 1..8 and divide DATA_WIDTH");
    end

    typedef enum logic {IDLE, SHIFT} stateT;

    stateT                       state, stateNext;
    logic [SW-1:0]               sCount, sNext;
    logic [CW-1:0]               holdBuf, holdBufNext;
    logic                        holdValid, holdValidNext;
    logic [CW-1:0]               shifter, shiftNext;
    logic [CW-1:0]               loadWord;
    logic [CHANNELS*OUT_BITS-1:0] dataOutNext;
    logic                        wordStartNext;
    logic [15:0]                 gapNext;
    logic                        lastSlice, load, accept, gapEvent;

    function automatic logic [CW-1:0] laneOrder(input logic [CW-1:0] w);
        logic [CW-1:0] r;
        r = w;
        if (MSB_FIRST) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
                    r[c*DATA_WIDTH + b] = w[c*DATA_WIDTH + DATA_WIDTH - 1 - b];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CHANNELS*OUT_BITS-1:0] lowSlices(input logic [CW-1:0] w);
        logic [CHANNELS*OUT_BITS-1:0] s;
        s = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            s[c*OUT_BITS +: OUT_BITS] = w[c*DATA_WIDTH +: OUT_BITS];
        end
        return s;
    endfunction

    function automatic logic [CW-1:0] shiftLanes(input logic [CW-1:0] w);
        logic [CW-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            r[c*DATA_WIDTH +: DATA_WIDTH] = w[c*DATA_WIDTH +: DATA_WIDTH] >> OUT_BITS;
        end
        return r;
    endfunction

    assign lastSlice = (sCount == LAST);
    assign load      = holdValid & ((state == IDLE) | lastSlice);
    assign inReady   = resetN & clockEnable & (~holdValid | load);
    assign accept    = inValid & inReady;
    assign loadWord  = laneOrder(holdBuf);
    assign gapEvent  = (state == SHIFT) & lastSlice & ~load;

    always_comb begin
        stateNext     = state;
        sNext         = sCount;
        shiftNext     = shifter;
        dataOutNext   = dataOut;
        wordStartNext = wordStart;
        holdBufNext   = holdBuf;
        holdValidNext = holdValid;
        gapNext       = gapCount;

        if (load) begin
            shiftNext     = shiftLanes(loadWord);
            dataOutNext   = lowSlices(loadWord);
            sNext         = '0;
            stateNext     = SHIFT;
            wordStartNext = 1'b1;
            holdValidNext = 1'b0;
        end else if ((state == SHIFT) && !lastSlice) begin
            shiftNext     = shiftLanes(shifter);
            dataOutNext   = lowSlices(shifter);
            sNext         = sCount + SW'(1);
            wordStartNext = 1'b0;
        end else begin
            stateNext     = IDLE;
            sNext         = '0;
            dataOutNext   = {CHANNELS{IDLE_PATTERN}};
            wordStartNext = 1'b0;
        end

        // A same-edge accept refills the buffer the load just drained.
        if (accept) begin
            holdBufNext   = dataIn;
            holdValidNext = 1'b1;
        end

        if (clearGapCount) begin
            gapNext = '0;
        end else if (gapEvent && (gapCount != '1)) begin
            gapNext = gapCount + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= IDLE;
            sCount    <= '0;
            holdBuf   <= '0;
            holdValid <= 1'b0;
            shifter   <= '0;
            dataOut   <= {CHANNELS{IDLE_PATTERN}};
            wordStart <= 1'b0;
            gapCount  <= '0;
        end else if (clockEnable) begin
            state     <= stateNext;
            sCount    <= sNext;
            holdBuf   <= holdBufNext;
            holdValid <= holdValidNext;
            shifter   <= shiftNext;
            dataOut   <= dataOutNext;
            wordStart <= wordStartNext;
            gapCount  <= gapNext;
        end
    end

endmodule

// File: tb/tb_output_serdes_gearbox.sv
// Directed bench for output_serdes_gearbox: vector table on the default build,
// plus hand sequences for MSB_FIRST, OUT_BITS=8 and gap-count saturation.
module tb_output_serdes_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default instance: 2 x 8 bit, 4 bits out, LSB first
    logic        rstN, ce, valid, clr, rdy, ws;
    logic [15:0] din, gap;
    logic [7:0]  dout;

    output_serdes_gearbox #(.CHANNELS(2), .DATA_WIDTH(8), .OUT_BITS(4), .MSB_FIRST(1'b0),
                            .IDLE_PATTERN(4'b0101)) dut (
        .clk(clk), .resetN(rstN), .clockEnable(ce), .inValid(valid), .inReady(rdy),
        .dataIn(din), .dataOut(dout), .wordStart(ws), .gapCount(gap), .clearGapCount(clr));

    // MSB-first instance
    logic        rstM, validM, rdyM, wsM;
    logic [15:0] dinM, gapM;
    logic [7:0]  doutM;

    output_serdes_gearbox #(.CHANNELS(2), .DATA_WIDTH(8), .OUT_BITS(4), .MSB_FIRST(1'b1),
                            .IDLE_PATTERN(4'b0101)) dutM (
        .clk(clk), .resetN(rstM), .clockEnable(1'b1), .inValid(validM), .inReady(rdyM),
        .dataIn(dinM), .dataOut(doutM), .wordStart(wsM), .gapCount(gapM), .clearGapCount(1'b0));

    // One slice per word instance
    logic        rst8, valid8, rdy8, ws8;
    logic [15:0] din8, gap8, dout8;

    output_serdes_gearbox #(.CHANNELS(2), .DATA_WIDTH(8), .OUT_BITS(8), .MSB_FIRST(1'b0),
                            .IDLE_PATTERN(8'hA5)) dut8 (
        .clk(clk), .resetN(rst8), .clockEnable(1'b1), .inValid(valid8), .inReady(rdy8),
        .dataIn(din8), .dataOut(dout8), .wordStart(ws8), .gapCount(gap8), .clearGapCount(1'b0));

    typedef struct {
        logic        rst, ce, valid, clr;
        logic [15:0] din;
        logic        expRdy;
        logic [7:0]  expOut;
        logic        expWs;
        logic [15:0] expGap;
    } vecT;

    vecT vecs[32];

    function automatic vecT mk(input logic r, input logic e, input logic v, input logic c,
                               input logic [15:0] d, input logic rd, input logic [7:0] o,
                               input logic w, input logic [15:0] g);
        vecT t;
        t.rst = r; t.ce = e; t.valid = v; t.clr = c; t.din = d;
        t.expRdy = rd; t.expOut = o; t.expWs = w; t.expGap = g;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] words8[6];

    initial begin
        rstN = 1'b0; ce = 1'b1; valid = 1'b0; clr = 1'b0; din = '0;
        rstM = 1'b0; validM = 1'b0; dinM = '0;
        rst8 = 1'b0; valid8 = 1'b0; din8 = '0;

        //            rst ce  v  clr din       rdy out    ws gap
        vecs[0]  = mk(0, 1, 0, 0, 16'h0000, 0, 8'h55, 0, 16'd0);
        vecs[1]  = mk(0, 1, 0, 0, 16'h0000, 0, 8'h55, 0, 16'd0);
        vecs[2]  = mk(0, 1, 0, 0, 16'h0000, 0, 8'h55, 0, 16'd0);
        vecs[3]  = mk(1, 1, 0, 0, 16'h0000, 1, 8'h55, 0, 16'd0);
        vecs[4]  = mk(1, 1, 1, 0, 16'h5CA3, 1, 8'h55, 0, 16'd0);
        vecs[5]  = mk(1, 1, 0, 0, 16'h0000, 1, 8'hC3, 1, 16'd0);
        vecs[6]  = mk(1, 1, 0, 0, 16'h0000, 1, 8'h5A, 0, 16'd0);
        vecs[7]  = mk(1, 1, 0, 0, 16'h0000, 1, 8'h55, 0, 16'd1);
        vecs[8]  = mk(1, 1, 0, 1, 16'h0000, 1, 8'h55, 0, 16'd0);
        vecs[9]  = mk(1, 1, 1, 0, 16'h1234, 1, 8'h55, 0, 16'd0);
        vecs[10] = mk(1, 1, 1, 0, 16'hABCD, 1, 8'h24, 1, 16'd0);
        vecs[11] = mk(1, 1, 1, 0, 16'h9E60, 0, 8'h13, 0, 16'd0);
        vecs[12] = mk(1, 1, 1, 0, 16'h9E60, 1, 8'hBD, 1, 16'd0);
        vecs[13] = mk(1, 1, 1, 0, 16'h0FF0, 0, 8'hAC, 0, 16'd0);
        vecs[14] = mk(1, 1, 1, 0, 16'h0FF0, 1, 8'hE0, 1, 16'd0);
        vecs[15] = mk(1, 1, 0, 0, 16'h0000, 0, 8'h96, 0, 16'd0);
        vecs[16] = mk(1, 1, 0, 0, 16'h0000, 1, 8'hF0, 1, 16'd0);
        vecs[17] = mk(1, 1, 0, 0, 16'h0000, 1, 8'h0F, 0, 16'd0);
        vecs[18] = mk(1, 1, 0, 0, 16'h0000, 1, 8'h55, 0, 16'd1);
        vecs[19] = mk(1, 1, 1, 0, 16'h7E81, 1, 8'h55, 0, 16'd1);
        vecs[20] = mk(1, 1, 0, 0, 16'h0000, 1, 8'hE1, 1, 16'd1);
        vecs[21] = mk(1, 0, 1, 0, 16'hFFFF, 0, 8'hE1, 1, 16'd1);
        vecs[22] = mk(1, 0, 1, 0, 16'hFFFF, 0, 8'hE1, 1, 16'd1);
        vecs[23] = mk(1, 0, 1, 0, 16'hFFFF, 0, 8'hE1, 1, 16'd1);
        vecs[24] = mk(1, 1, 0, 0, 16'h0000, 1, 8'h78, 0, 16'd1);
        vecs[25] = mk(1, 1, 0, 1, 16'h0000, 1, 8'h55, 0, 16'd0);
        vecs[26] = mk(1, 1, 0, 0, 16'h0000, 1, 8'h55, 0, 16'd0);
        vecs[27] = mk(1, 1, 1, 0, 16'h3C4B, 1, 8'h55, 0, 16'd0);
        vecs[28] = mk(1, 1, 1, 0, 16'h6677, 1, 8'hCB, 1, 16'd0);
        vecs[29] = mk(0, 1, 0, 0, 16'h0000, 0, 8'h55, 0, 16'd0);
        vecs[30] = mk(1, 1, 0, 0, 16'h0000, 1, 8'h55, 0, 16'd0);
        vecs[31] = mk(1, 1, 0, 0, 16'h0000, 1, 8'h55, 0, 16'd0);

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rstN = vecs[i].rst; ce = vecs[i].ce; valid = vecs[i].valid;
            clr = vecs[i].clr; din = vecs[i].din;
            #1;
            check($sformatf("vec%0d inReady", i), 32'(rdy), 32'(vecs[i].expRdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d dataOut", i), 32'(dout), 32'(vecs[i].expOut));
            check($sformatf("vec%0d wordStart", i), 32'(ws), 32'(vecs[i].expWs));
            check($sformatf("vec%0d gapCount", i), 32'(gap), 32'(vecs[i].expGap));
        end

        // Saturation: preload one below the ceiling, then two gaps
        @(negedge clk);
        valid = 1'b0; clr = 1'b0;
        force dut.gapCount = 16'hFFFE;
        #1;
        release dut.gapCount;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            valid = 1'b1; din = 16'h1357;
            @(negedge clk);
            valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("gap saturate %0d", g), 32'(gap), 32'h0000FFFF);
            check($sformatf("gap saturate idle %0d", g), 32'(dout), 32'h55);
        end

        // MSB first: ch0=A3 reverses to C5, ch1=3C is a palindrome
        @(negedge clk);
        rstM = 1'b1;
        @(negedge clk);
        validM = 1'b1; dinM = 16'h3CA3;
        #1;
        check("msb inReady", 32'(rdyM), 32'd1);
        @(negedge clk);
        validM = 1'b0;
        @(posedge clk);
        #1;
        check("msb slice0", 32'(doutM), 32'hC5);
        check("msb slice0 ch0", 32'(doutM[3:0]), 32'h5);
        check("msb wordStart", 32'(wsM), 32'd1);
        @(posedge clk);
        #1;
        check("msb slice1", 32'(doutM), 32'h3C);
        check("msb slice1 ch0", 32'(doutM[3:0]), 32'hC);
        @(posedge clk);
        #1;
        check("msb idle", 32'(doutM), 32'h55);
        check("msb gap", 32'(gapM), 32'd1);

        // One slice per word: continuous valid streams one word per clock
        words8[0] = 16'hA1B2; words8[1] = 16'hC3D4; words8[2] = 16'hE5F6;
        words8[3] = 16'h0718; words8[4] = 16'h293A; words8[5] = 16'h4B5C;
        @(negedge clk);
        rst8 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            valid8 = 1'b1; din8 = words8[k];
            #1;
            check($sformatf("ob8 inReady %0d", k), 32'(rdy8), 32'd1);
            @(posedge clk);
            #1;
            if (k == 0) begin
                check("ob8 first idle", 32'(dout8), 32'hA5A5);
            end else begin
                check($sformatf("ob8 word %0d", k - 1), 32'(dout8), 32'(words8[k-1]));
                check($sformatf("ob8 wordStart %0d", k - 1), 32'(ws8), 32'd1);
            end
        end
        @(negedge clk);
        valid8 = 1'b0;
        #1;
        check("ob8 inReady drain", 32'(rdy8), 32'd1);
        @(posedge clk);
        #1;
        check("ob8 word 5", 32'(dout8), 32'(words8[5]));
        @(posedge clk);
        #1;
        check("ob8 idle", 32'(dout8), 32'hA5A5);
        check("ob8 gap", 32'(gap8), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
